// File: rtl/ap_accum_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ap_accum_array
// Description : Multi-lane saturating accumulator (optionally approximate low
//               bits) that sums one N-term vector stream per job.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_accum_array #(
    parameter int WIDTH       = 12,
    parameter int LANES       = 3,
    parameter int TERMS_W     = 8,
    parameter int APPROX_BITS = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [TERMS_W-1:0]       n_terms,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   c_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_min = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [TERMS_W-1:0] c_one = TERMS_W'(1);

    state_t                  r_state;
    logic [TERMS_W-1:0]      r_count;
    logic [LANES*WIDTH-1:0]  r_acc;
    logic [LANES-1:0]        r_sat;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;

    logic [LANES*WIDTH-1:0]  w_sum;
    logic [LANES-1:0]        w_clamp;
    logic                    w_beat;

    assign w_beat = in_valid & r_in_ready;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [WIDTH-1:0] w_a;
            logic [WIDTH-1:0] w_x;
            logic [WIDTH:0]   w_s;

            assign w_a = r_acc[l*WIDTH +: WIDTH];
            assign w_x = in_data[l*WIDTH +: WIDTH];

            if (APPROX_BITS == 0) begin : g_exact
                assign w_s = {w_a[WIDTH-1], w_a} + {w_x[WIDTH-1], w_x};
            end else begin : g_approx
                localparam int c_k = APPROX_BITS;
                logic [WIDTH-c_k:0] w_hi;
                logic               w_cin;

                // Lower-part-OR: low bits are ORed, their top AND feeds the exact upper adder.
                assign w_cin = w_a[c_k-1] & w_x[c_k-1];
                assign w_hi  = {w_a[WIDTH-1], w_a[WIDTH-1:c_k]}
                             + {w_x[WIDTH-1], w_x[WIDTH-1:c_k]}
                             + {{(WIDTH-c_k){1'b0}}, w_cin};
                assign w_s   = {w_hi, w_a[c_k-1:0] | w_x[c_k-1:0]};
            end

            // The extra sum bit disagreeing with the sign bit means the lane left range.
            assign w_clamp[l] = w_s[WIDTH] ^ w_s[WIDTH-1];
            assign w_sum[l*WIDTH +: WIDTH] = w_clamp[l] ? (w_s[WIDTH] ? c_min : c_max)
                                                        : w_s[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_sat       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_sat  <= '0;
                        r_busy <= 1'b1;
                        if (n_terms != '0) begin
                            r_count    <= n_terms;
                            r_in_ready <= 1'b1;
                            r_state    <= S_ACCUM;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_sum;
                        r_sat   <= r_sat | w_clamp;
                        r_count <= r_count - c_one;
                        if (r_count == c_one) begin
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_sat   = r_sat;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ap_accum_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ap_accum_array
// Description : Scoreboard bench for ap_accum_array, exact and approximate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_accum_array;

    localparam int WIDTH   = 12;
    localparam int LANES   = 3;
    localparam int TERMS_W = 8;
    localparam int AB      = 4;
    localparam int MAXV    = (1 << (WIDTH-1)) - 1;
    localparam int MINV    = -(1 << (WIDTH-1));

    typedef struct {
        logic [LANES*WIDTH-1:0] data;
        logic [LANES-1:0]       sat;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [TERMS_W-1:0]     n_terms;
    logic                   in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_ready;

    logic                   in_ready_e, out_valid_e, busy_e;
    logic [LANES*WIDTH-1:0] out_data_e;
    logic [LANES-1:0]       out_sat_e;
    logic                   in_ready_a, out_valid_a, busy_a;
    logic [LANES*WIDTH-1:0] out_data_a;
    logic [LANES-1:0]       out_sat_a;

    exp_t q_e[$];
    exp_t q_a[$];
    int   bt[256][LANES];
    int   n_checks;
    int   n_fail;
    bit   rand_ready;

    ap_accum_array #(.WIDTH(WIDTH), .LANES(LANES), .TERMS_W(TERMS_W), .APPROX_BITS(0)) u_exact (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
        .in_valid(in_valid), .in_ready(in_ready_e), .in_data(in_data),
        .out_valid(out_valid_e), .out_ready(out_ready), .out_data(out_data_e),
        .out_sat(out_sat_e), .busy(busy_e)
    );

    ap_accum_array #(.WIDTH(WIDTH), .LANES(LANES), .TERMS_W(TERMS_W), .APPROX_BITS(AB)) u_approx (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_sat(out_sat_a), .busy(busy_a)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference lane add: plain integer arithmetic, low k bits ORed, then clamp.
    function automatic int lane_add(input int a, input int x, input int k, output bit sat);
        int s, p, lo, cin;
        if (k == 0) begin
            s = a + x;
        end else begin
            p   = 1 << k;
            lo  = (a | x) & (p - 1);
            cin = ((a >>> (k-1)) & 1) & ((x >>> (k-1)) & 1);
            s   = ((a >>> k) + (x >>> k) + cin) * p + lo;
        end
        sat = 1'b0;
        if (s > MAXV) begin s = MAXV; sat = 1'b1; end
        else if (s < MINV) begin s = MINV; sat = 1'b1; end
        return s;
    endfunction

    function automatic logic [LANES*WIDTH-1:0] pack(input int j);
        logic [LANES*WIDTH-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = bt[j][l][WIDTH-1:0];
        return v;
    endfunction

    task automatic check_rst(input string name);
        check({name, "_out_valid"}, 64'(out_valid_e | out_valid_a), 64'd0);
        check({name, "_in_ready"},  64'(in_ready_e | in_ready_a),   64'd0);
        check({name, "_busy"},      64'(busy_e | busy_a),           64'd0);
        check({name, "_out_data"},  64'(out_data_e | out_data_a),   64'd0);
        check({name, "_out_sat"},   64'(out_sat_e | out_sat_a),     64'd0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_e || q_e.size() != 0 || q_a.size() != 0) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) fail_now("wait_idle_timeout");
    endtask

    task automatic fill_random(input int n);
        int mode;
        for (int j = 0; j < n; j++) begin
            for (int l = 0; l < LANES; l++) begin
                mode = int'($urandom_range(0, 2));
                if (mode == 0)      bt[j][l] = int'($urandom_range(0, 4095)) - 2048;
                else if (mode == 1) bt[j][l] = int'($urandom_range(0, 200)) - 100;
                else                bt[j][l] = int'($urandom_range(1500, 2047));
            end
        end
    endtask

    // Issue one job of n beats from bt; abort_after >= 0 pulses reset before that beat.
    task automatic run_job(input int n, input int abort_after);
        exp_t ee, ea;
        int   ae, aa, t;
        bit   s, se, sa, rdy;
        ee.data = '0; ee.sat = '0;
        ea.data = '0; ea.sat = '0;
        for (int l = 0; l < LANES; l++) begin
            ae = 0; aa = 0; se = 0; sa = 0;
            for (int j = 0; j < n; j++) begin
                ae = lane_add(ae, bt[j][l], 0, s);  se |= s;
                aa = lane_add(aa, bt[j][l], AB, s); sa |= s;
            end
            ee.data[l*WIDTH +: WIDTH] = ae[WIDTH-1:0];
            ea.data[l*WIDTH +: WIDTH] = aa[WIDTH-1:0];
            ee.sat[l] = se;
            ea.sat[l] = sa;
        end
        wait_idle();
        if (abort_after < 0) begin
            q_e.push_back(ee);
            q_a.push_back(ea);
        end
        start = 1'b1;
        n_terms = TERMS_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        n_terms = TERMS_W'($urandom_range(0, 255));
        for (int j = 0; j < n; j++) begin
            if (abort_after == j) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_rst("abort");
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = pack(j);
            t = 0;
            rdy = 1'b0;
            while (!rdy) begin
                @(negedge clk);
                rdy = in_ready_e;
                @(posedge clk); #1;
                t++;
                if (!rdy && t > 50) begin
                    fail_now("beat_accept_timeout");
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        check("latency_out_valid", 64'(out_valid_e & out_valid_a), 64'd1);
        check("done_in_ready", 64'(in_ready_e | in_ready_a), 64'd0);
    endtask

    // Monitor: pops one expected result per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_e && out_ready) begin
            if (q_e.size() == 0) fail_now("exact_unexpected_result");
            else begin
                e = q_e.pop_front();
                check("exact_data", 64'(out_data_e), 64'(e.data));
                check("exact_sat",  64'(out_sat_e),  64'(e.sat));
            end
        end
        if (rst_n && out_valid_a && out_ready) begin
            if (q_a.size() == 0) fail_now("approx_unexpected_result");
            else begin
                e = q_a.pop_front();
                check("approx_data", 64'(out_data_a), 64'(e.data));
                check("approx_sat",  64'(out_sat_a),  64'(e.sat));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*WIDTH-1:0] held_e, held_a;
        logic [LANES-1:0]       held_se, held_sa;
        exp_t z;
        int   n;

        n_checks = 0; n_fail = 0; rand_ready = 1'b0;
        rst_n = 1'b0; start = 1'b0; n_terms = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_rst("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_ready = 1'b1;

        // Saturation high on lane0, plain sum on lane1, saturation low on lane2.
        bt[0][0] = 2047; bt[0][1] = 10;  bt[0][2] = -1000;
        bt[1][0] = 3;    bt[1][1] = 100; bt[1][2] = -1100;
        run_job(2, -1);

        // Approximate lane0 7+9 -> 15, lane1 10+100 -> 110.
        bt[0][0] = 7; bt[0][1] = 10;  bt[0][2] = -37;
        bt[1][0] = 9; bt[1][1] = 100; bt[1][2] = 512;
        run_job(2, -1);

        for (int jb = 0; jb < 20; jb++) begin
            n = (jb == 19) ? 255 : int'($urandom_range(1, 12));
            fill_random(n);
            run_job(n, -1);
        end

        // Zero-term job: result next cycle, no beat consumed.
        wait_idle();
        rand_ready = 1'b0;
        out_ready = 1'b0;
        z.data = '0; z.sat = '0;
        q_e.push_back(z);
        q_a.push_back(z);
        start = 1'b1; n_terms = '0; in_valid = 1'b1; in_data = '1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_out_valid", 64'(out_valid_e & out_valid_a), 64'd1);
        check("zero_busy", 64'(busy_e), 64'd1);
        @(posedge clk); #1;
        check("zero_in_ready", 64'(in_ready_e | in_ready_a), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("zero_popped", 64'(q_e.size() + q_a.size()), 64'd0);
        check("zero_idle", 64'(busy_e | out_valid_e), 64'd0);

        // Back-pressure in DONE with an ignored start pulse.
        fill_random(3);
        run_job(3, -1);
        held_e = out_data_e; held_a = out_data_a;
        held_se = out_sat_e; held_sa = out_sat_a;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; n_terms = 8'd4; end
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_data_e", 64'(out_data_e), 64'(held_e));
            check("hold_data_a", 64'(out_data_a), 64'(held_a));
            check("hold_sat", 64'({out_sat_e, out_sat_a}), 64'({held_se, held_sa}));
            check("hold_valid", 64'(out_valid_e), 64'd1);
            check("hold_in_ready", 64'(in_ready_e), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_valid", 64'(out_valid_e), 64'd0);
        check("hold_release_busy", 64'(busy_e | busy_a), 64'd0);
        rand_ready = 1'b1;

        // Reset mid-job, then a clean one-beat job.
        for (int j = 0; j < 4; j++)
            for (int l = 0; l < LANES; l++) bt[j][l] = 100 * (j + 1) + l;
        run_job(4, 2);
        for (int l = 0; l < LANES; l++) bt[0][l] = 5;
        run_job(1, -1);

        wait_idle();
        check("final_queue_empty", 64'(q_e.size() + q_a.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
